// File: rtl/mem_wb_stage.sv
// Writeback stage: registers one memory-stage result per accepted instruction,
// drives the register-file write port and the RET PC redirect, and splits
// LW.POI into two consecutive register writes (Rd, then Rs1).
module mem_wb_stage #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned REG_AW   = 5,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        opcode,
  input  logic              reg_write_in,
  input  logic [REG_AW-1:0] rd_idx,
  input  logic [REG_AW-1:0] rs1_idx,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] addr_rs1,
  input  logic [DATA_W-1:0] stack_out,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              pc_load,
  output logic [DATA_W-1:0] pc_target,
  output logic              retired,
  output logic [31:0]       retired_count
);

  localparam logic [5:0] OpLw    = 6'b000101;
  localparam logic [5:0] OpPop   = 6'b010000;
  localparam logic [5:0] OpLwPoi = 6'b000110;
  localparam logic [5:0] OpSw    = 6'b000111;
  localparam logic [5:0] OpPush  = 6'b001111;
  localparam logic [5:0] OpCall  = 6'b001101;
  localparam logic [5:0] OpRet   = 6'b001110;

  typedef enum logic [2:0] {ClsAlu, ClsLoad, ClsPoi, ClsNowb, ClsRet} op_cls_e;
  typedef enum logic {StIdle, StPoi2} state_e;

  state_e              r_state, w_state_d;
  logic                r_wb_en, w_wb_en_d;
  logic [REG_AW-1:0]   r_wb_addr, w_wb_addr_d;
  logic [DATA_W-1:0]   r_wb_data, w_wb_data_d;
  logic                r_pc_load, w_pc_load_d;
  logic [DATA_W-1:0]   r_pc_target, w_pc_target_d;
  logic                r_retired, w_retired_d;
  logic [31:0]         r_retired_count, w_retired_count_d;
  // Second LW.POI write, captured at accept and replayed in StPoi2.
  logic [REG_AW-1:0]   r_poi_idx, w_poi_idx_d;
  logic [DATA_W-1:0]   r_poi_data, w_poi_data_d;

  op_cls_e w_cls;
  logic    w_accept;

  assign in_ready = rst_n && (r_state == StIdle);
  assign w_accept = in_valid && in_ready;

  // Decode the opcode into a writeback class.
  always_comb begin
    w_cls = ClsAlu;
    case (opcode)
      OpLw, OpPop:          w_cls = ClsLoad;
      OpLwPoi:              w_cls = ClsPoi;
      OpSw, OpPush, OpCall: w_cls = ClsNowb;
      OpRet:                w_cls = ClsRet;
      default:              w_cls = ClsAlu;
    endcase
  end

  // Next-state and next-output selection; address/data/target hold when idle.
  always_comb begin
    w_state_d         = r_state;
    w_wb_en_d         = 1'b0;
    w_wb_addr_d       = r_wb_addr;
    w_wb_data_d       = r_wb_data;
    w_pc_load_d       = 1'b0;
    w_pc_target_d     = r_pc_target;
    w_retired_d       = 1'b0;
    w_retired_count_d = r_retired_count;
    w_poi_idx_d       = r_poi_idx;
    w_poi_data_d      = r_poi_data;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_retired_d = 1'b1;
          case (w_cls)
            ClsLoad: begin
              w_wb_en_d   = reg_write_in;
              w_wb_addr_d = rd_idx;
              w_wb_data_d = mem_data;
            end
            ClsAlu: begin
              w_wb_en_d   = reg_write_in;
              w_wb_addr_d = rd_idx;
              w_wb_data_d = alu_result;
            end
            ClsRet: begin
              w_pc_load_d   = 1'b1;
              w_pc_target_d = stack_out;
            end
            ClsPoi: begin
              w_wb_en_d    = 1'b1;
              w_wb_addr_d  = rd_idx;
              w_wb_data_d  = mem_data;
              w_poi_idx_d  = rs1_idx;
              w_poi_data_d = addr_rs1;
              w_state_d    = StPoi2;
              // Retirement is credited on the second write.
              w_retired_d  = 1'b0;
            end
            default: ;
          endcase
        end
      end
      StPoi2: begin
        w_wb_en_d   = 1'b1;
        w_wb_addr_d = r_poi_idx;
        w_wb_data_d = r_poi_data;
        w_retired_d = 1'b1;
        w_state_d   = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
    if (w_retired_d) begin
      w_retired_count_d = r_retired_count + 32'd1;
    end
    if (ZERO_REG && (w_wb_addr_d == '0)) begin
      w_wb_en_d = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= StIdle;
      r_wb_en         <= 1'b0;
      r_wb_addr       <= '0;
      r_wb_data       <= '0;
      r_pc_load       <= 1'b0;
      r_pc_target     <= '0;
      r_retired       <= 1'b0;
      r_retired_count <= '0;
      r_poi_idx       <= '0;
      r_poi_data      <= '0;
    end else begin
      r_state         <= w_state_d;
      r_wb_en         <= w_wb_en_d;
      r_wb_addr       <= w_wb_addr_d;
      r_wb_data       <= w_wb_data_d;
      r_pc_load       <= w_pc_load_d;
      r_pc_target     <= w_pc_target_d;
      r_retired       <= w_retired_d;
      r_retired_count <= w_retired_count_d;
      r_poi_idx       <= w_poi_idx_d;
      r_poi_data      <= w_poi_data_d;
    end
  end

  assign wb_en         = r_wb_en;
  assign wb_addr       = r_wb_addr;
  assign wb_data       = r_wb_data;
  assign pc_load       = r_pc_load;
  assign pc_target     = r_pc_target;
  assign retired       = r_retired;
  assign retired_count = r_retired_count;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: expected output vectors are pushed to a
// scoreboard queue as instructions are driven and popped one per output cycle.
module tb_mem_wb_stage;

  localparam logic [5:0] OpAlu   = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b000101;
  localparam logic [5:0] OpPop   = 6'b010000;
  localparam logic [5:0] OpLwPoi = 6'b000110;
  localparam logic [5:0] OpSw    = 6'b000111;
  localparam logic [5:0] OpPush  = 6'b001111;
  localparam logic [5:0] OpCall  = 6'b001101;
  localparam logic [5:0] OpRet   = 6'b001110;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  opcode;
  logic        reg_write_in;
  logic [4:0]  rd_idx;
  logic [4:0]  rs1_idx;
  logic [31:0] alu_result;
  logic [31:0] mem_data;
  logic [31:0] addr_rs1;
  logic [31:0] stack_out;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        pc_load;
  logic [31:0] pc_target;
  logic        retired;
  logic [31:0] retired_count;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .opcode       (opcode),
    .reg_write_in (reg_write_in),
    .rd_idx       (rd_idx),
    .rs1_idx      (rs1_idx),
    .alu_result   (alu_result),
    .mem_data     (mem_data),
    .addr_rs1     (addr_rs1),
    .stack_out    (stack_out),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .pc_load      (pc_load),
    .pc_target    (pc_target),
    .retired      (retired),
    .retired_count(retired_count)
  );

  // Observed output vector: {wb_en, wb_addr, wb_data, pc_load, pc_target, retired, retired_count}.
  logic [103:0] obs;
  assign obs = {wb_en, wb_addr, wb_data, pc_load, pc_target, retired, retired_count};

  logic [103:0] sb_q[$];
  logic [103:0] exp_v;
  int           n_pass  = 0;
  int           n_total = 0;

  // Reference model of held values and the retirement counter.
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [31:0] m_pct;
  logic [31:0] m_cnt;
  logic [5:0]  nowb_ops[3];

  task automatic push_exp(input logic en, input logic [4:0] addr, input logic [31:0] data,
                          input logic pcl, input logic [31:0] pct, input logic ret);
    if (ret) m_cnt = m_cnt + 32'd1;
    m_addr = addr;
    m_data = data;
    m_pct  = pct;
    sb_q.push_back({en, addr, data, pcl, pct, ret, m_cnt});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [5:0] op, input logic rw, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [31:0] alu, input logic [31:0] mem,
                      input logic [31:0] a1, input logic [31:0] stk);
    in_valid     = 1'b1;
    opcode       = op;
    reg_write_in = rw;
    rd_idx       = rd;
    rs1_idx      = rs1;
    alu_result   = alu;
    mem_data     = mem;
    addr_rs1     = a1;
    stack_out    = stk;
  endtask

  task automatic idle();
    in_valid     = 1'b0;
    opcode       = OpAlu;
    reg_write_in = 1'b1;
    rd_idx       = 5'd31;
    rs1_idx      = 5'd30;
    alu_result   = 32'hFFFF_0000;
    mem_data     = 32'hEEEE_0000;
    addr_rs1     = 32'hDDDD_0000;
    stack_out    = 32'hCCCC_0000;
  endtask

  task automatic model_reset();
    m_addr = '0;
    m_data = '0;
    m_pct  = '0;
    m_cnt  = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    model_reset();
    step();
    step();
    n_total++;
    if (obs !== 104'd0) $display("FAIL reset_outputs got=%h exp=%h", obs, 104'd0);
    else n_pass++;
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", in_ready);
    else n_pass++;
    rst_n = 1'b1;
    #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL ready_after_reset got=%b exp=1", in_ready);
    else n_pass++;
  endtask

  task automatic test_alu();
    send(OpAlu, 1'b1, 5'd3, 5'd0, 32'h1234_5678, 32'h0000_AAAA, 32'd0, 32'd0);
    push_exp(1'b1, 5'd3, 32'h1234_5678, 1'b0, m_pct, 1'b1);
    step();
    idle();
    exp_v = sb_q.pop_front();
    n_total++;
    if (obs !== exp_v) $display("FAIL alu_write got=%h exp=%h", obs, exp_v);
    else n_pass++;
    push_exp(1'b0, m_addr, m_data, 1'b0, m_pct, 1'b0);
    step();
    exp_v = sb_q.pop_front();
    n_total++;
    if (obs !== exp_v) $display("FAIL idle_hold got=%h exp=%h", obs, exp_v);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    send(OpLw, 1'b1, 5'd7, 5'd1, 32'h0000_1111, 32'hCAFE_F00D, 32'd0, 32'd0);
    push_exp(1'b1, 5'd7, 32'hCAFE_F00D, 1'b0, m_pct, 1'b1);
    step();
    exp_v = sb_q.pop_front();
    n_total++;
    if (obs !== exp_v) $display("FAIL b2b_lw got=%h exp=%h", obs, exp_v);
    else n_pass++;
    send(OpAlu, 1'b0, 5'd9, 5'd1, 32'h0000_0055, 32'h0000_0066, 32'd0, 32'd0);
    push_exp(1'b0, 5'd9, 32'h0000_0055, 1'b0, m_pct, 1'b1);
    step();
    exp_v = sb_q.pop_front();
    n_total++;
    if (obs !== exp_v) $display("FAIL b2b_alu_nowrite got=%h exp=%h", obs, exp_v);
    else n_pass++;
    send(OpPop, 1'b1, 5'd12, 5'd1, 32'h0000_0088, 32'h0000_0077, 32'd0, 32'd0);
    push_exp(1'b1, 5'd12, 32'h0000_0077, 1'b0, m_pct, 1'b1);
    step();
    idle();
    exp_v = sb_q.pop_front();
    n_total++;
    if (obs !== exp_v) $display("FAIL b2b_pop got=%h exp=%h", obs, exp_v);
    else n_pass++;
  endtask

  task automatic test_lw_poi();
    int waited;
    send(OpLwPoi, 1'b1, 5'd4, 5'd5, 32'h0000_0999, 32'hDEAD_BEEF, 32'h0000_0101, 32'd0);
    push_exp(1'b1, 5'd4, 32'hDEAD_BEEF, 1'b0, m_pct, 1'b0);
    push_exp(1'b1, 5'd5, 32'h0000_0101, 1'b0, m_pct, 1'b1);
    step();
    // Next instruction queued while the stage is back-pressuring.
    send(OpAlu, 1'b1, 5'd6, 5'd7, 32'h0000_0066, 32'h0000_0011, 32'h0000_0022, 32'd0);
    exp_v = sb_q.pop_front();
    n_total++;
    if (obs !== exp_v) $display("FAIL poi_first_write got=%h exp=%h", obs, exp_v);
    else n_pass++;
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL poi2_in_ready got=%b exp=0", in_ready);
    else n_pass++;
    step();
    exp_v = sb_q.pop_front();
    n_total++;
    if (obs !== exp_v) $display("FAIL poi_second_write got=%h exp=%h", obs, exp_v);
    else n_pass++;
    waited = 0;
    while (in_ready !== 1'b1 && waited < 8) begin
      step();
      waited++;
    end
    n_total++;
    if (waited != 0) $display("FAIL poi_single_bubble got=%0d extra_cycles exp=0", waited);
    else n_pass++;
    push_exp(1'b1, 5'd6, 32'h0000_0066, 1'b0, m_pct, 1'b1);
    step();
    idle();
    exp_v = sb_q.pop_front();
    n_total++;
    if (obs !== exp_v) $display("FAIL poi_follow_alu got=%h exp=%h", obs, exp_v);
    else n_pass++;
  endtask

  task automatic test_poi_corners();
    send(OpLwPoi, 1'b1, 5'd8, 5'd8, 32'd0, 32'h0000_0001, 32'h0000_0002, 32'd0);
    push_exp(1'b1, 5'd8, 32'h0000_0001, 1'b0, m_pct, 1'b0);
    push_exp(1'b1, 5'd8, 32'h0000_0002, 1'b0, m_pct, 1'b1);
    step();
    idle();
    exp_v = sb_q.pop_front();
    n_total++;
    if (obs !== exp_v) $display("FAIL poi_same_first got=%h exp=%h", obs, exp_v);
    else n_pass++;
    step();
    exp_v = sb_q.pop_front();
    n_total++;
    if (obs !== exp_v) $display("FAIL poi_same_second got=%h exp=%h", obs, exp_v);
    else n_pass++;
    send(OpLwPoi, 1'b1, 5'd13, 5'd0, 32'd0, 32'h0000_0ABC, 32'h0000_0123, 32'd0);
    push_exp(1'b1, 5'd13, 32'h0000_0ABC, 1'b0, m_pct, 1'b0);
    push_exp(1'b0, 5'd0, 32'h0000_0123, 1'b0, m_pct, 1'b1);
    step();
    idle();
    exp_v = sb_q.pop_front();
    n_total++;
    if (obs !== exp_v) $display("FAIL poi_r0_first got=%h exp=%h", obs, exp_v);
    else n_pass++;
    step();
    exp_v = sb_q.pop_front();
    n_total++;
    if (obs !== exp_v) $display("FAIL poi_r0_second got=%h exp=%h", obs, exp_v);
    else n_pass++;
  endtask

  task automatic test_ret();
    send(OpRet, 1'b1, 5'd2, 5'd1, 32'h0000_0BAD, 32'h0000_0BAD, 32'd0, 32'h0000_0040);
    push_exp(1'b0, m_addr, m_data, 1'b1, 32'h0000_0040, 1'b1);
    step();
    idle();
    exp_v = sb_q.pop_front();
    n_total++;
    if (obs !== exp_v) $display("FAIL ret_redirect got=%h exp=%h", obs, exp_v);
    else n_pass++;
    push_exp(1'b0, m_addr, m_data, 1'b0, m_pct, 1'b0);
    step();
    exp_v = sb_q.pop_front();
    n_total++;
    if (obs !== exp_v) $display("FAIL ret_one_cycle got=%h exp=%h", obs, exp_v);
    else n_pass++;
  endtask

  task automatic test_nowb();
    nowb_ops[0] = OpSw;
    nowb_ops[1] = OpPush;
    nowb_ops[2] = OpCall;
    for (int i = 0; i < 3; i++) begin
      send(nowb_ops[i], 1'b1, 5'd10, 5'd1, 32'h0000_0BAD, 32'h0000_0BAD, 32'd0, 32'd0);
      push_exp(1'b0, m_addr, m_data, 1'b0, m_pct, 1'b1);
      step();
      exp_v = sb_q.pop_front();
      n_total++;
      if (obs !== exp_v) $display("FAIL nowb_op%0d got=%h exp=%h", i, obs, exp_v);
      else n_pass++;
    end
    send(OpPop, 1'b1, 5'd0, 5'd1, 32'd0, 32'h0000_0099, 32'd0, 32'd0);
    push_exp(1'b0, 5'd0, 32'h0000_0099, 1'b0, m_pct, 1'b1);
    step();
    idle();
    exp_v = sb_q.pop_front();
    n_total++;
    if (obs !== exp_v) $display("FAIL pop_r0_suppressed got=%h exp=%h", obs, exp_v);
    else n_pass++;
  endtask

  task automatic test_reset_in_poi2();
    send(OpLwPoi, 1'b1, 5'd11, 5'd12, 32'd0, 32'h0000_0ABC, 32'h0000_0DEF, 32'd0);
    push_exp(1'b1, 5'd11, 32'h0000_0ABC, 1'b0, m_pct, 1'b0);
    step();
    exp_v = sb_q.pop_front();
    n_total++;
    if (obs !== exp_v) $display("FAIL rst_poi_first got=%h exp=%h", obs, exp_v);
    else n_pass++;
    rst_n = 1'b0;
    idle();
    model_reset();
    step();
    n_total++;
    if (obs !== 104'd0) $display("FAIL rst_poi2_outputs got=%h exp=%h", obs, 104'd0);
    else n_pass++;
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL rst_poi2_in_ready got=%b exp=0", in_ready);
    else n_pass++;
    rst_n = 1'b1;
    #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL rst_poi2_ready_after got=%b exp=1", in_ready);
    else n_pass++;
    push_exp(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    step();
    exp_v = sb_q.pop_front();
    n_total++;
    if (obs !== exp_v) $display("FAIL rst_poi2_dropped got=%h exp=%h", obs, exp_v);
    else n_pass++;
  endtask

  task automatic test_count_wrap();
    dut.r_retired_count = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    send(OpAlu, 1'b1, 5'd1, 5'd2, 32'h0000_0005, 32'd0, 32'd0, 32'd0);
    push_exp(1'b1, 5'd1, 32'h0000_0005, 1'b0, m_pct, 1'b1);
    step();
    idle();
    exp_v = sb_q.pop_front();
    n_total++;
    if (obs !== exp_v) $display("FAIL count_wrap got=%h exp=%h", obs, exp_v);
    else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_lw_poi();
    test_poi_corners();
    test_ret();
    test_nowb();
    test_reset_in_poi2();
    test_count_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
